// File: rtl/hls_seq_pkg.sv
// Shared types for the HLS run sequencer: FSM states, record status codes
// and a helper for the channel-index width.
package hls_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRST,
        S_START,
        S_RUN,
        S_REPORT,
        S_FIN
    } state_e;

    typedef enum logic [1:0] {
        ST_OK            = 2'b00,
        ST_TIMEOUT       = 2'b01,
        ST_DONE_AT_START = 2'b10
    } status_e;

    // Channel index width, never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hls_run_timer.sv
// Per-channel run timer: saturating cycle counter with watchdog, latches the
// first done (or the timeout) as cycles/status and raises finished.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   load_i         start cycle: counter loads 1, done here is DONE_AT_START
//   en_i           run phase: count until done or TIMEOUT
//   done_i         accelerator done
//   finished_o     channel has a latched result
//   cycles_o       latched cycle count
//   status_o       latched status
module hls_run_timer
    import hls_seq_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 200000000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             done_i,
    output logic             finished_o,
    output logic [CNT_W-1:0] cycles_o,
    output status_e          status_o
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             fin_q, fin_d;
    status_e          status_q, status_d;

    // cnt_inc is the count a done seen in the current cycle would report.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + ONE;

    // Next-state: load on start, then count until the first finish event.
    always_comb begin
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        fin_d    = fin_q;
        status_d = status_q;
        if (load_i) begin
            cnt_d    = ONE;
            fin_d    = 1'b0;
            cycles_d = '0;
            status_d = ST_OK;
            if (done_i) begin
                fin_d    = 1'b1;
                cycles_d = ONE;
                status_d = ST_DONE_AT_START;
            end else if (TMO <= ONE) begin
                fin_d    = 1'b1;
                cycles_d = TMO;
                status_d = ST_TIMEOUT;
            end
        end else if (en_i && !fin_q) begin
            cnt_d = cnt_inc;
            if (done_i) begin
                fin_d    = 1'b1;
                cycles_d = cnt_inc;
                status_d = ST_OK;
            end else if (cnt_inc >= TMO) begin
                fin_d    = 1'b1;
                cycles_d = TMO;
                status_d = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            cycles_q <= '0;
            fin_q    <= 1'b0;
            status_q <= ST_OK;
        end else begin
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            fin_q    <= fin_d;
            status_q <= status_d;
        end
    end

    assign finished_o = fin_q;
    assign cycles_o   = cycles_q;
    assign status_o   = status_q;

endmodule

// File: rtl/hls_run_sequencer.sv
// Multi-channel run controller for Bambu accelerators: per run it pulses a
// local DUT reset, starts every channel, times each done, then streams one
// result record per channel over valid/ready.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   go_i, cfg_runs_i   batch start (IDLE only) and run count
//   busy_o, all_done_o batch in progress, end-of-batch pulse
//   dut_reset_o        active-low accelerator reset
//   start_port_o       per-channel start pulse
//   done_port_i        per-channel done
//   res_*              result record stream
module hls_run_sequencer
    import hls_seq_pkg::*;
#(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned TIMEOUT    = 200000000,
    parameter int unsigned RUNS_W     = 16,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        go_i,
    input  logic [RUNS_W-1:0]           cfg_runs_i,
    output logic                        busy_o,
    output logic                        all_done_o,
    output logic                        dut_reset_o,
    output logic [N_CH-1:0]             start_port_o,
    input  logic [N_CH-1:0]             done_port_i,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [ch_width(N_CH)-1:0]   res_ch_o,
    output logic [RUNS_W-1:0]           res_run_o,
    output logic [CNT_W-1:0]            res_cycles_o,
    output logic [1:0]                  res_status_o
);

    localparam int unsigned CH_W   = ch_width(N_CH);
    localparam int unsigned DRST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e              state_q, state_d;
    logic [RUNS_W-1:0]   runs_q, runs_d;
    logic [RUNS_W-1:0]   run_idx_q, run_idx_d;
    logic [DRST_W-1:0]   drst_cnt_q, drst_cnt_d;
    logic                busy_q, busy_d;
    logic                all_done_q, all_done_d;
    logic                dut_reset_q, dut_reset_d;
    logic [N_CH-1:0]     start_q, start_d;
    logic                res_valid_q, res_valid_d;
    logic [CH_W-1:0]     res_ch_q, res_ch_d;
    logic [RUNS_W-1:0]   res_run_q, res_run_d;
    logic [CNT_W-1:0]    res_cycles_q, res_cycles_d;
    status_e             res_status_q, res_status_d;

    logic [N_CH-1:0]     t_fin;
    logic [CNT_W-1:0]    t_cycles [N_CH];
    status_e             t_status [N_CH];

    logic [CH_W-1:0]     next_ch;
    logic [RUNS_W:0]     next_idx;
    logic                more_runs;

    // One timer per channel; driven straight from the registered state.
    for (genvar c = 0; c < N_CH; c++) begin : g_timer
        hls_run_timer #(
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT)
        ) u_timer (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .load_i     (state_q == S_START),
            .en_i       (state_q == S_RUN),
            .done_i     (done_port_i[c]),
            .finished_o (t_fin[c]),
            .cycles_o   (t_cycles[c]),
            .status_o   (t_status[c])
        );
    end

    assign next_ch   = res_ch_q + CH_W'(1);
    assign next_idx  = {1'b0, run_idx_q} + (RUNS_W+1)'(1);
    assign more_runs = next_idx < {1'b0, runs_q};

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        runs_d       = runs_q;
        run_idx_d    = run_idx_q;
        drst_cnt_d   = drst_cnt_q;
        busy_d       = busy_q;
        all_done_d   = 1'b0;
        dut_reset_d  = dut_reset_q;
        start_d      = '0;
        res_valid_d  = res_valid_q;
        res_ch_d     = res_ch_q;
        res_run_d    = res_run_q;
        res_cycles_d = res_cycles_q;
        res_status_d = res_status_q;

        unique case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    runs_d    = cfg_runs_i;
                    run_idx_d = '0;
                    if (cfg_runs_i == '0) begin
                        state_d    = S_FIN;
                        all_done_d = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        state_d     = S_DRST;
                        busy_d      = 1'b1;
                        dut_reset_d = 1'b0;
                        drst_cnt_d  = '0;
                    end
                end
            end
            S_DRST: begin
                if (drst_cnt_q == DRST_W'(RST_CYCLES - 1)) begin
                    state_d     = S_START;
                    dut_reset_d = 1'b1;
                    start_d     = '1;
                end else begin
                    drst_cnt_d = drst_cnt_q + DRST_W'(1);
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (&t_fin) begin
                    state_d      = S_REPORT;
                    res_valid_d  = 1'b1;
                    res_ch_d     = '0;
                    res_run_d    = run_idx_q;
                    res_cycles_d = t_cycles[0];
                    res_status_d = t_status[0];
                end
            end
            S_REPORT: begin
                if (res_valid_q && res_ready_i) begin
                    if (res_ch_q == CH_W'(N_CH - 1)) begin
                        res_valid_d = 1'b0;
                        if (more_runs) begin
                            run_idx_d   = next_idx[RUNS_W-1:0];
                            state_d     = S_DRST;
                            dut_reset_d = 1'b0;
                            drst_cnt_d  = '0;
                        end else begin
                            state_d    = S_FIN;
                            all_done_d = 1'b1;
                            busy_d     = 1'b0;
                        end
                    end else begin
                        res_ch_d     = next_ch;
                        res_cycles_d = t_cycles[next_ch];
                        res_status_d = t_status[next_ch];
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            runs_q       <= '0;
            run_idx_q    <= '0;
            drst_cnt_q   <= '0;
            busy_q       <= 1'b0;
            all_done_q   <= 1'b0;
            dut_reset_q  <= 1'b0;
            start_q      <= '0;
            res_valid_q  <= 1'b0;
            res_ch_q     <= '0;
            res_run_q    <= '0;
            res_cycles_q <= '0;
            res_status_q <= ST_OK;
        end else begin
            state_q      <= state_d;
            runs_q       <= runs_d;
            run_idx_q    <= run_idx_d;
            drst_cnt_q   <= drst_cnt_d;
            busy_q       <= busy_d;
            all_done_q   <= all_done_d;
            dut_reset_q  <= dut_reset_d;
            start_q      <= start_d;
            res_valid_q  <= res_valid_d;
            res_ch_q     <= res_ch_d;
            res_run_q    <= res_run_d;
            res_cycles_q <= res_cycles_d;
            res_status_q <= res_status_d;
        end
    end

    assign busy_o       = busy_q;
    assign all_done_o   = all_done_q;
    assign dut_reset_o  = dut_reset_q;
    assign start_port_o = start_q;
    assign res_valid_o  = res_valid_q;
    assign res_ch_o     = res_ch_q;
    assign res_run_o    = res_run_q;
    assign res_cycles_o = res_cycles_q;
    assign res_status_o = res_status_q;

endmodule
